ex_muldiv: RTL

Parametrised iterative multiply/divide unit for the execute stage, alongside the single-cycle ALU. It accepts an operation when the decoded instruction reaches execute, holds the pipeline via `stall` while it iterates, and delivers a registered HI/LO result tagged with the destination register. Operand width is generic. The unit supports signed and unsigned multiply and divide, an abort on `flush`, and defined divide-by-zero results.

---
 rtl/ex_muldiv_if.sv | 28 ++
 rtl/ex_muldiv.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_if.sv
// Operand/result bundle between the execute stage and the iterative multiply/divide unit.
interface ex_muldiv_if #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
);
  logic             start;
  logic [1:0]       op;
  logic             flush;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [TAGW-1:0]  dst;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [TAGW-1:0]  dst_out;

  modport master (
    output start, op, flush, a, b, dst,
    input  busy, stall, done, hi, lo, dst_out
  );

  modport slave (
    input  start, op, flush, a, b, dst,
    output busy, stall, done, hi, lo, dst_out
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative signed/unsigned multiply and divide for the execute stage.
// Works on operand magnitudes for WIDTH cycles, then applies the latched result signs.
module ex_muldiv #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
) (
  input logic         CLK,
  input logic         nRST,
  ex_muldiv_if.slave  mdu
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic               isDiv_q, isDiv_d;
  logic               negRes_q, negRes_d;
  logic               negRem_q, negRem_d;
  logic [WIDTH-1:0]   addend_q, addend_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [TAGW-1:0]    dstReg_q, dstReg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [TAGW-1:0]    dstOut_q, dstOut_d;

  logic               signA, signB;
  logic [WIDTH-1:0]   aMag, bMag;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divShift;
  logic               divGe;
  logic [WIDTH-1:0]   divRem;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix, remFix;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      count_q  <= '0;
      isDiv_q  <= 1'b0;
      negRes_q <= 1'b0;
      negRem_q <= 1'b0;
      addend_q <= '0;
      acc_q    <= '0;
      dstReg_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dstOut_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      isDiv_q  <= isDiv_d;
      negRes_q <= negRes_d;
      negRem_q <= negRem_d;
      addend_q <= addend_d;
      acc_q    <= acc_d;
      dstReg_q <= dstReg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dstOut_q <= dstOut_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    isDiv_d  = isDiv_q;
    negRes_d = negRes_q;
    negRem_d = negRem_q;
    addend_d = addend_q;
    acc_d    = acc_q;
    dstReg_d = dstReg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dstOut_d = dstOut_q;

    signA = mdu.op[0] & mdu.a[WIDTH-1];
    signB = mdu.op[0] & mdu.b[WIDTH-1];
    aMag  = signA ? -mdu.a : mdu.a;
    bMag  = signB ? -mdu.b : mdu.b;

    // Multiply keeps the partial sum in the upper half and shifts the multiplier out of the lower half;
    // divide keeps the partial remainder in the upper half and shifts quotient bits into the lower half.
    mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? addend_q : '0)};
    divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    divGe    = (divShift >= {1'b0, addend_q});
    divRem   = divGe ? WIDTH'(divShift - {1'b0, addend_q}) : divShift[WIDTH-1:0];

    prodFix = negRes_q ? -acc_q : acc_q;
    quoFix  = negRes_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    remFix  = negRem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      IDLE: begin
        if (mdu.start) begin
          isDiv_d  = mdu.op[1];
          negRes_d = signA ^ signB;
          negRem_d = signA;
          dstReg_d = mdu.dst;
          count_d  = '0;
          if (mdu.op[1] && (mdu.b == '0)) begin
            hi_d     = mdu.a;
            lo_d     = '1;
            dstOut_d = mdu.dst;
            state_d  = DONE;
          end else if (mdu.op[1]) begin
            acc_d    = {{WIDTH{1'b0}}, aMag};
            addend_d = bMag;
            state_d  = RUN;
          end else begin
            acc_d    = {{WIDTH{1'b0}}, bMag};
            addend_d = aMag;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (isDiv_q) begin
          acc_d = {divRem, acc_q[WIDTH-2:0], divGe};
        end else begin
          acc_d = {mulSum, acc_q[WIDTH-1:1]};
        end
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (isDiv_q) begin
          hi_d = remFix;
          lo_d = quoFix;
        end else begin
          hi_d = prodFix[2*WIDTH-1:WIDTH];
          lo_d = prodFix[WIDTH-1:0];
        end
        dstOut_d = dstReg_q;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A flush wins over everything except reset and must never publish a result.
    if (mdu.flush) begin
      state_d  = IDLE;
      hi_d     = hi_q;
      lo_d     = lo_q;
      dstOut_d = dstOut_q;
    end
  end

  assign mdu.busy    = (state_q == RUN) || (state_q == FIX);
  assign mdu.stall   = mdu.busy || (mdu.start && (state_q == IDLE) && !mdu.flush);
  assign mdu.done    = (state_q == DONE);
  assign mdu.hi      = hi_q;
  assign mdu.lo      = lo_q;
  assign mdu.dst_out = dstOut_q;

endmodule
